// File: rtl/serial_frame_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_rx_if
// Purpose  : Bundles the serial-line inputs, the word valid/ready handshake
//            and the status/error flags of serial_frame_rx into one port.
//
// Signals  :
//   enable      bit strobe; serialin is sampled only when enable=1
//   leftright   bit order (0 = MSB first, 1 = LSB first), latched on start
//   serialin    serial line, idles high
//   pdataout    received word, stable while dvalid=1
//   dvalid      word available
//   dready      consumer accepts the word when dvalid & dready
//   busy        receiver is inside a frame (state != IDLE)
//   frame_err   one-cycle pulse: stop bit sampled 0
//   parity_err  one-cycle pulse: even-parity mismatch
//   overrun     one-cycle pulse: completed word dropped, dvalid still held
//
// Modports :
//   master  the receiver itself (drives word and status)
//   slave   the line driver / consumer side
//
// Revision : 1.0  initial release
// ============================================================================
interface serial_frame_rx_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic             leftright;
    logic             serialin;
    logic [WIDTH-1:0] pdataout;
    logic             dvalid;
    logic             dready;
    logic             busy;
    logic             frame_err;
    logic             parity_err;
    logic             overrun;

    modport master (
        input  enable,
        input  leftright,
        input  serialin,
        input  dready,
        output pdataout,
        output dvalid,
        output busy,
        output frame_err,
        output parity_err,
        output overrun
    );

    modport slave (
        output enable,
        output leftright,
        output serialin,
        output dready,
        input  pdataout,
        input  dvalid,
        input  busy,
        input  frame_err,
        input  parity_err,
        input  overrun
    );
endinterface
`default_nettype wire

// File: rtl/serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_rx
// Purpose  : Serial-to-parallel frame receiver. Samples one line bit per
//            enable strobe and recognises frames of the form
//              start(0), WIDTH data bits, [even parity], stop(1).
//            Completed words are offered on a valid/ready handshake; framing,
//            parity and overrun conditions are flagged with one-cycle pulses.
//
// Ports    :
//   clock   system clock, rising edge
//   reset   asynchronous, active-high; clears all state and outputs
//   rx      serial_frame_rx_if.master (line, handshake and status signals)
//
// Parameter:
//   WIDTH   data bits per frame, 2..32 (must match the interface WIDTH)
//
// Build option:
//   SERIAL_FRAME_RX_PARITY_EN  when defined, a parity bit follows the data
//                              bits and even parity is checked; otherwise
//                              the frame is WIDTH+2 strobes and parity_err
//                              is tied low.
//
// Revision : 1.0  initial release
// ============================================================================
module serial_frame_rx #(
    parameter int WIDTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    serial_frame_rx_if.master rx
);

    // Counter holds 0..WIDTH, so it never wraps inside a frame.
    localparam int                 c_cnt_w    = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [2:0] {
        c_idle    = 3'd0,
        c_data    = 3'd1,
`ifdef SERIAL_FRAME_RX_PARITY_EN
        c_parity  = 3'd2,
`endif
        c_stop    = 3'd3,
        c_recover = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_shift;
    logic               r_lsb_first;
    logic [WIDTH-1:0]   r_pdataout;
    logic               r_dvalid;
    logic               r_busy;
    logic               r_frame_err;
    logic               r_overrun;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic               r_par;
    logic               r_parity_err;
`endif

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic               w_lsb_first_nxt;
    logic [WIDTH-1:0]   w_pdataout_nxt;
    logic               w_dvalid_nxt;
    logic               w_busy_nxt;
    logic               w_frame_err_nxt;
    logic               w_overrun_nxt;
    logic               w_word_done;
    logic [WIDTH-1:0]   w_shift_in;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic               w_par_nxt;
    logic               w_parity_err_nxt;
    logic               w_parity_ok;
`endif

    // Shift register with the current line bit inserted. MSB-first frames
    // enter at bit 0 and move up; LSB-first frames enter at the top and move
    // down, so the first bit received ends up at bit 0.
    assign w_shift_in = r_lsb_first ? {rx.serialin, r_shift[WIDTH-1:1]}
                                    : {r_shift[WIDTH-2:0], rx.serialin};

`ifdef SERIAL_FRAME_RX_PARITY_EN
    // Even parity: data bits plus parity bit must XOR to zero.
    assign w_parity_ok = ~((^r_shift) ^ r_par);
`endif

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_shift_nxt      = r_shift;
        w_lsb_first_nxt  = r_lsb_first;
        w_frame_err_nxt  = 1'b0;
        w_word_done      = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
        w_par_nxt        = r_par;
        w_parity_err_nxt = 1'b0;
`endif

        // Everything in the frame FSM advances on strobes only.
        case (r_state)
            c_idle: begin
                if (rx.enable && !rx.serialin) begin
                    // Bit order is frozen for the whole frame here.
                    w_lsb_first_nxt = rx.leftright;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = c_data;
                end
            end

            c_data: begin
                if (rx.enable) begin
                    w_shift_nxt = w_shift_in;
                    w_cnt_nxt   = r_cnt + c_cnt_one;
                    if (r_cnt == c_cnt_last) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        w_state_nxt = c_parity;
`else
                        w_state_nxt = c_stop;
`endif
                    end
                end
            end

`ifdef SERIAL_FRAME_RX_PARITY_EN
            c_parity: begin
                if (rx.enable) begin
                    w_par_nxt   = rx.serialin;
                    w_state_nxt = c_stop;
                end
            end
`endif

            c_stop: begin
                if (rx.enable) begin
                    if (!rx.serialin) begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = c_recover;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                    end else if (!w_parity_ok) begin
                        w_parity_err_nxt = 1'b1;
                        w_state_nxt      = c_idle;
`endif
                    end else begin
                        w_word_done = 1'b1;
                        w_state_nxt = c_idle;
                    end
                end
            end

            c_recover: begin
                // A line stuck low after a bad stop bit must not look like a
                // stream of start bits; wait until it is seen high again.
                if (rx.enable && rx.serialin) begin
                    w_state_nxt = c_idle;
                end
            end

            default: begin
                w_state_nxt = c_idle;
            end
        endcase

        // Word handshake runs every cycle, independent of the strobe.
        w_pdataout_nxt = r_pdataout;
        w_dvalid_nxt   = r_dvalid;
        w_overrun_nxt  = 1'b0;
        if (w_word_done) begin
            if (!r_dvalid || rx.dready) begin
                // Either the slot is empty or it is being emptied this cycle.
                w_pdataout_nxt = r_shift;
                w_dvalid_nxt   = 1'b1;
            end else begin
                // Keep the unread word; the new one is lost.
                w_overrun_nxt = 1'b1;
            end
        end else if (r_dvalid && rx.dready) begin
            w_dvalid_nxt = 1'b0;
        end

        // busy is registered from the next state so it tracks the FSM with
        // no combinational path to the output.
        w_busy_nxt = (w_state_nxt != c_idle);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= c_idle;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_lsb_first  <= 1'b0;
            r_pdataout   <= '0;
            r_dvalid     <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_lsb_first  <= w_lsb_first_nxt;
            r_pdataout   <= w_pdataout_nxt;
            r_dvalid     <= w_dvalid_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_err  <= w_frame_err_nxt;
            r_overrun    <= w_overrun_nxt;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            r_par        <= w_par_nxt;
            r_parity_err <= w_parity_err_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rx.pdataout  = r_pdataout;
    assign rx.dvalid    = r_dvalid;
    assign rx.busy      = r_busy;
    assign rx.frame_err = r_frame_err;
    assign rx.overrun   = r_overrun;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    assign rx.parity_err = r_parity_err;
`else
    assign rx.parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_frame_rx
// Purpose  : Directed self-checking bench for serial_frame_rx (WIDTH=4).
//            Inputs change on the falling clock edge; outputs are checked on
//            the falling edge, half a cycle after the rising edge that
//            updated them.
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_frame_rx;

    logic clock;
    logic reset;
    int   errors;
    int   checks;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic par_flip;
`endif

    serial_frame_rx_if #(.WIDTH(4)) bus ();

    serial_frame_rx #(.WIDTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .rx    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: set the inputs sampled at the next rising edge.
    task automatic tick(input logic en, input logic sin, input logic rdy, input logic lr);
        @(negedge clock);
        bus.enable    = en;
        bus.serialin  = sin;
        bus.dready    = rdy;
        bus.leftright = lr;
    endtask

    // Drive a full frame. gap = idle (enable=0) cycles before each strobe
    // after the start bit. leftright is inverted after the start bit to show
    // it is ignored mid-frame. dready is raised only on the stop strobe.
    task automatic send_frame(input logic lr, input logic [3:0] data, input logic stop,
                              input int gap, input logic rdy_stop);
        logic b;
        tick(1'b1, 1'b0, 1'b0, lr);
        for (int i = 0; i < 4; i++) begin
            b = lr ? data[i] : data[3-i];
            for (int g = 0; g < gap; g++) tick(1'b0, ~b, 1'b0, ~lr);
            tick(1'b1, b, 1'b0, ~lr);
        end
`ifdef SERIAL_FRAME_RX_PARITY_EN
        b = (^data) ^ par_flip;
        for (int g = 0; g < gap; g++) tick(1'b0, ~b, 1'b0, ~lr);
        tick(1'b1, b, 1'b0, ~lr);
`endif
        for (int g = 0; g < gap; g++) tick(1'b0, 1'b0, 1'b0, ~lr);
        tick(1'b1, stop, rdy_stop, ~lr);
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reset         = 1'b1;
        bus.enable    = 1'b0;
        bus.serialin  = 1'b1;
        bus.leftright = 1'b0;
        bus.dready    = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
        par_flip      = 1'b0;
`endif

        // ---------------- reset state ----------------
        repeat (3) tick(1'b1, 1'b1, 1'b0, 1'b0);
        chk("rst_pdataout",   32'(bus.pdataout),   32'h0);
        chk("rst_dvalid",     32'(bus.dvalid),     32'h0);
        chk("rst_busy",       32'(bus.busy),       32'h0);
        chk("rst_frame_err",  32'(bus.frame_err),  32'h0);
        chk("rst_parity_err", 32'(bus.parity_err), 32'h0);
        chk("rst_overrun",    32'(bus.overrun),    32'h0);
        reset = 1'b0;
        tick(1'b1, 1'b1, 1'b0, 1'b0);

        // ---------------- basic MSB-first: 1010 ----------------
        send_frame(1'b0, 4'b1010, 1'b1, 0, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        chk("msb_dvalid",    32'(bus.dvalid),    32'h1);
        chk("msb_pdataout",  32'(bus.pdataout),  32'hA);
        chk("msb_busy_fell", 32'(bus.busy),      32'h0);
        chk("msb_no_ferr",   32'(bus.frame_err), 32'h0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        chk("msb_accept_clr", 32'(bus.dvalid),   32'h0);

        // ---------------- LSB-first, strobe every third cycle ----------------
        send_frame(1'b1, 4'b1010, 1'b1, 2, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("lsb_dvalid",   32'(bus.dvalid),   32'h1);
        chk("lsb_pdataout", 32'(bus.pdataout), 32'hA);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("lsb_accept_noen", 32'(bus.dvalid), 32'h0);

        // ---------------- framing error, line held low ----------------
        send_frame(1'b0, 4'b1100, 1'b0, 0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("ferr_pulse",    32'(bus.frame_err), 32'h1);
        chk("ferr_no_valid", 32'(bus.dvalid),    32'h0);
        chk("ferr_busy",     32'(bus.busy),      32'h1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("ferr_one_cycle", 32'(bus.frame_err), 32'h0);
        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        chk("ferr_recover_busy", 32'(bus.busy), 32'h1);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        chk("ferr_idle_busy",   32'(bus.busy),   32'h0);
        chk("ferr_no_frame",    32'(bus.dvalid), 32'h0);

        // ---------------- overrun, back-to-back frames ----------------
        send_frame(1'b0, 4'h3, 1'b1, 0, 1'b0);
        send_frame(1'b0, 4'h5, 1'b1, 0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        chk("ovr_pulse",    32'(bus.overrun),  32'h1);
        chk("ovr_keep_old", 32'(bus.pdataout), 32'h3);
        chk("ovr_dvalid",   32'(bus.dvalid),   32'h1);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        chk("ovr_one_cycle", 32'(bus.overrun), 32'h0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        chk("ovr_accept_clr", 32'(bus.dvalid), 32'h0);

        // ---------------- simultaneous accept and completion ----------------
        send_frame(1'b0, 4'h3, 1'b1, 0, 1'b0);
        send_frame(1'b0, 4'h5, 1'b1, 0, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        chk("sim_pdataout",   32'(bus.pdataout), 32'h5);
        chk("sim_dvalid",     32'(bus.dvalid),   32'h1);
        chk("sim_no_overrun", 32'(bus.overrun),  32'h0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        chk("sim_accept_clr", 32'(bus.dvalid), 32'h0);

        // ---------------- parity ----------------
`ifdef SERIAL_FRAME_RX_PARITY_EN
        par_flip = 1'b0;
        send_frame(1'b0, 4'b1010, 1'b1, 0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        chk("par_ok_dvalid",   32'(bus.dvalid),     32'h1);
        chk("par_ok_pdataout", 32'(bus.pdataout),   32'hA);
        chk("par_ok_no_perr",  32'(bus.parity_err), 32'h0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        par_flip = 1'b1;
        send_frame(1'b0, 4'b1010, 1'b1, 0, 1'b0);
        par_flip = 1'b0;
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        chk("par_bad_pulse",  32'(bus.parity_err), 32'h1);
        chk("par_bad_dvalid", 32'(bus.dvalid),     32'h0);
        chk("par_bad_busy",   32'(bus.busy),       32'h0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        chk("par_one_cycle",  32'(bus.parity_err), 32'h0);
`else
        send_frame(1'b0, 4'b0110, 1'b1, 0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        chk("nopar_dvalid",   32'(bus.dvalid),     32'h1);
        chk("nopar_pdataout", 32'(bus.pdataout),   32'h6);
        chk("nopar_perr_low", 32'(bus.parity_err), 32'h0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
`endif

        // ---------------- reset mid-frame ----------------
        send_frame(1'b0, 4'h9, 1'b1, 0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_dvalid",   32'(bus.dvalid),   32'h1);
        chk("pre_rst_pdataout", 32'(bus.pdataout), 32'h9);
        tick(1'b1, 1'b0, 1'b0, 1'b0);       // start
        tick(1'b1, 1'b1, 1'b0, 1'b0);       // data bit 1
        tick(1'b1, 1'b1, 1'b0, 1'b0);       // data bit 2
        tick(1'b1, 1'b0, 1'b0, 1'b0);       // data bit 3 (never sampled)
        chk("mid_busy", 32'(bus.busy), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_pdataout", 32'(bus.pdataout),  32'h0);
        chk("async_rst_dvalid",   32'(bus.dvalid),    32'h0);
        chk("async_rst_busy",     32'(bus.busy),      32'h0);
        chk("async_rst_ferr",     32'(bus.frame_err), 32'h0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(1'b0, 4'hC, 1'b1, 0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        chk("post_rst_pdataout", 32'(bus.pdataout), 32'hC);
        chk("post_rst_dvalid",   32'(bus.dvalid),   32'h1);
        chk("post_rst_no_ferr",  32'(bus.frame_err), 32'h0);
        chk("post_rst_no_ovr",   32'(bus.overrun),  32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
